// File: rtl/debug_mailbox_pkg.sv
// Shared register map and bit positions for the HPS-to-fabric debug mailbox.
// Address decode constants, STATUS/CTRL bit indices and a STATUS word packer.
// Used by the mailbox top and its FIFO so both agree on widths and layout.
package debug_mailbox_pkg;

  localparam int DATA_W = 32;

  // Avalon register addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_OUT    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit positions; the fill count lives in [8:0]
  localparam int ST_CNT_W = 9;
  localparam int ST_FULL  = 16;
  localparam int ST_EMPTY = 17;
  localparam int ST_OVF   = 18;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  // Assemble the STATUS read word; every unmapped bit reads as zero.
  function automatic logic [DATA_W-1:0] status_word(
    input logic [ST_CNT_W-1:0] cnt,
    input logic                full,
    input logic                empty,
    input logic                ovf
  );
    logic [DATA_W-1:0] w;
    w               = '0;
    w[ST_CNT_W-1:0] = cnt;
    w[ST_FULL]      = full;
    w[ST_EMPTY]     = empty;
    w[ST_OVF]       = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous show-ahead FIFO: head word is always visible on data_o.
// Latency: a push becomes visible on data_o/empty_o one cycle later (no bypass).
// Backpressure: push while full is ignored unless a pop happens the same cycle; flush wins over both.
module mailbox_fifo
  import debug_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              push_ok;
  logic              pop_ok;
  logic              mem_we;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and count; a pop frees a slot for a same-cycle push into a full FIFO.
  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    mem_we   = push_ok && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/debug_out_mailbox.sv
// Avalon-MM slave mailbox: HPS pushes 32-bit words, fabric drains them with valid/ready; plus a level out_port.
// Latency: readdata registered (1 cycle); pushed word visible on fifo_data/fifo_valid the cycle after the write.
// Backpressure: fifo_ready low holds the head; a push into a full FIFO with no pop is dropped and sets sticky overflow.
module debug_out_mailbox
  import debug_mailbox_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] OUT_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port,
  output logic [31:0] fifo_data,
  output logic        fifo_valid,
  input  logic        fifo_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0] readdata_q, readdata_d;
  logic [31:0] out_q,      out_d;
  logic [31:0] shadow_q,   shadow_d;
  logic        ovf_q,      ovf_d;
  logic        en_q,       en_d;

  logic          wr;
  logic          push;
  logic          pop;
  logic          flush;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign wr    = chipselect && !write_n;
  assign push  = wr && (address == ADDR_DATA);
  assign flush = wr && (address == ADDR_CTRL) && writedata[CTRL_FLUSH];

  // Empty comes from an async-reset count, so fifo_valid falls straight away with reset_n.
  assign fifo_valid = !fifo_empty && en_q;
  assign pop        = fifo_valid && fifo_ready;

  assign readdata = readdata_q;
  assign out_port = out_q;

  mailbox_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (writedata),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Register-file next state; overflow set takes priority over a same-cycle clear.
  always_comb begin
    out_d    = out_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    en_d     = en_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   shadow_d = writedata;
        ADDR_STATUS: if (writedata[ST_OVF]) ovf_d = 1'b0;
        ADDR_OUT:    out_d = writedata;
        default:     en_d = writedata[CTRL_EN];
      endcase
    end
    if (push && fifo_full && !pop && !flush) ovf_d = 1'b1;
  end

  // Read mux sampled every edge from pre-update state, independent of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:   readdata_d = shadow_q;
      ADDR_STATUS: readdata_d = status_word(ST_CNT_W'(fifo_count), fifo_full, fifo_empty, ovf_q);
      ADDR_OUT:    readdata_d = out_q;
      default:     readdata_d[CTRL_EN] = en_q;
    endcase
  end

  // Architectural registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      out_q      <= OUT_RESET;
      shadow_q   <= '0;
      ovf_q      <= 1'b0;
      en_q       <= 1'b1;
    end else begin
      readdata_q <= readdata_d;
      out_q      <= out_d;
      shadow_q   <= shadow_d;
      ovf_q      <= ovf_d;
      en_q       <= en_d;
    end
  end

endmodule
